// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and beat counter width.
package fifo_arb_pkg;
    typedef enum logic [0:0] {ARB, LOCK} arb_state_t;
    localparam int BEAT_CNT_W = 8;
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req searching upward from last_id+1 (mod NUM_REQ).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    id
);
    localparam int unsigned N = NUM_REQ;

    always_comb begin
        found = 1'b0;
        id    = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            if (!found && req[ID_W'((int'(last_id) + off) % N)]) begin
                found = 1'b1;
                id    = ID_W'((int'(last_id) + off) % N);
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NUM_REQ producers (w_clk domain).
// Define FIFO_ARB_BURST_EN to lock each grant for up to BURST_LEN beats.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_LEN  = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          w_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          we,
    output logic [DATA_WIDTH-1:0]         din,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(BURST_LEN);

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic [ID_W-1:0]       lock_id_q, lock_id_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic                  cur_busy;
    logic [ID_W-1:0]       cur_id;
    logic                  xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .last_id (last_id_q),
        .found   (pick_found),
        .id      (pick_id)
    );

    // Reset gates the grant so nothing is accepted while rst is low.
    assign cur_id   = (state_q == LOCK) ? lock_id_q : pick_id;
    assign cur_busy = rst & ((state_q == LOCK) ? req_valid[lock_id_q] : pick_found);
    assign xfer     = cur_busy & ~full;

    always_ff @(posedge w_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB;
            last_id_q  <= ID_W'(NUM_REQ - 1);
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        last_id_d  = xfer ? cur_id : last_id_q;
        case (state_q)
            ARB: begin
                if (BURST_EN && BURST_LEN > 1 && xfer) begin
                    state_d    = LOCK;
                    lock_id_d  = cur_id;
                    beat_cnt_d = BEAT_CNT_W'(1);
                end
            end
            LOCK: begin
                if (!req_valid[lock_id_q]) begin
                    state_d = ARB;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q + 1'b1 == BURST_LAST) begin
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        busy      = cur_busy;
        we        = 1'b0;
        req_ready = '0;
        din       = '0;
        grant_id  = '0;
        if (cur_busy) begin
            grant_id          = cur_id;
            din               = req_data[int'(cur_id)*DATA_WIDTH +: DATA_WIDTH];
            we                = ~full;
            req_ready[cur_id] = ~full;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter; burst scenarios run when FIFO_ARB_BURST_EN is defined.
module tb_fifo_write_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int BURST_LEN = 4;

    logic                  w_clk = 1'b0;
    logic                  rst   = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*DW-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  full = 1'b0;
    logic                  we;
    logic [DW-1:0]         din;
    logic [1:0]            grant_id;
    logic                  busy;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 w_clk = ~w_clk;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .we        (we),
        .din       (din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        beat_t b;
        b.id   = id;
        b.data = data;
        exp_q.push_back(b);
    endtask

    // Cycles where no write may occur: sampled on the falling edge.
    task automatic check_quiet(input string tag, input logic exp_busy, input logic [1:0] exp_id);
        @(negedge w_clk);
        check({tag, ".we"}, 32'(we), 32'(1'b0));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(4'b0000));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(exp_id));
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    always @(negedge w_clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: got din=0x%0h grant=%0d expected no write at %0t",
                         din, grant_id, $time);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("mon.grant_id", 32'(grant_id), 32'(b.id));
                check("mon.din", 32'(din), 32'(b.data));
                check("mon.req_ready", 32'(req_ready), 32'(4'b0001 << b.id));
                check("mon.busy", 32'(busy), 32'(1'b1));
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));

        // Reset held with every producer requesting.
        rst       = 1'b0;
        req_valid = 4'b1111;
        check_quiet("reset0", 1'b0, 2'd0);
        step();
        check_quiet("reset1", 1'b0, 2'd0);
        step();

        // Release: producer 0 first, then rotation.
        rst = 1'b1;
        push(2'd0, 8'hA0);
        push(2'd1, 8'hA1);
        push(2'd2, 8'hA2);
        push(2'd3, 8'hA3);
        push(2'd0, 8'hA0);
        repeat (5) step();
        req_valid = '0;
        check_quiet("idle", 1'b0, 2'd0);
        step();

        // Sparse: producers 1 and 3 alternate.
        set_data(1, 8'h11);
        set_data(3, 8'h33);
        req_valid = 4'b1010;
        push(2'd1, 8'h11);
        push(2'd3, 8'h33);
        push(2'd1, 8'h11);
        push(2'd3, 8'h33);
        repeat (4) step();
        req_valid = '0;
        step();

        // Wrap: producer 3 was last, all valid -> 0 then each within 4 transfers.
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        req_valid = 4'b1111;
        push(2'd0, 8'hA0);
        push(2'd1, 8'hA1);
        push(2'd2, 8'hA2);
        push(2'd3, 8'hA3);
        repeat (4) step();
        req_valid = '0;
        step();

        // Backpressure on producer 2.
        set_data(2, 8'hA5);
        req_valid = 4'b0100;
        full      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_quiet("full", 1'b1, 2'd2);
            step();
        end
        full = 1'b0;
        push(2'd2, 8'hA5);
        step();
        req_valid = '0;
        check_quiet("after_full", 1'b0, 2'd0);
        step();

`ifdef FIFO_ARB_BURST_EN
        // Locked bursts of BURST_LEN beats.
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        reset_pulse();
        req_valid = 4'b1111;
        push(2'd0, 8'hA0);
        push(2'd0, 8'hA0);
        push(2'd0, 8'hA0);
        push(2'd0, 8'hA0);
        push(2'd1, 8'hA1);
        push(2'd1, 8'hA1);
        repeat (6) step();
        req_valid = 4'b1101;
        check_quiet("lock_drop", 1'b0, 2'd0);
        step();
        repeat (4) push(2'd2, 8'hA2);
        repeat (4) step();
        req_valid = '0;
        step();

        // Reset mid-burst restarts a full burst for producer 0.
        reset_pulse();
        req_valid = 4'b1111;
        push(2'd0, 8'hA0);
        push(2'd0, 8'hA0);
        repeat (2) step();
        rst = 1'b0;
        check_quiet("reset_mid", 1'b0, 2'd0);
        step();
        rst = 1'b1;
        repeat (4) push(2'd0, 8'hA0);
        push(2'd1, 8'hA1);
        repeat (5) step();
        req_valid = '0;
        step();
`endif

        repeat (2) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
